// File: rtl/clk_en_gen_if.sv
// Bundles the mode/step/divider controls and the divided-clock outputs of clk_en_gen.
// The master drives the controls; the slave (the generator) drives the clocks and status.
interface clk_en_gen_if #(
   parameter int N_CH  = 5,
   parameter int CNT_W = 32
);
   logic [1:0]            mode;
   logic                  step_btn;
   logic [N_CH*CNT_W-1:0] div_val;
   logic                  sync_restart;
   logic [N_CH-1:0]       div_clk;
   logic [N_CH-1:0]       tick;
   logic                  step_pulse;
   logic                  running;

   modport master (
      output mode, step_btn, div_val, sync_restart,
      input  div_clk, tick, step_pulse, running
   );

   modport slave (
      input  mode, step_btn, div_val, sync_restart,
      output div_clk, tick, step_pulse, running
   );
endinterface

// File: rtl/clk_en_gen.sv
// Multi-channel clock divider with stop/step/run gating and a debounced step button.
// Optional phase-align restart is compiled in with CLK_EN_GEN_SYNC_RESTART_EN.
module clk_en_gen #(
   parameter int              N_CH      = 5,
   parameter int              CNT_W     = 32,
   parameter logic [N_CH-1:0] GATE_MASK = 5'b00111,
   parameter logic [15:0]     DEB_CNT   = 16'd1000
) (
   input  logic        clk,
   input  logic        rst,
   clk_en_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic [1:0] {S_STOP, S_WAIT, S_ARMED, S_RUN} state_t;

   logic             r_btn_s1, r_btn_s2;
   logic             r_deb_lvl;
   logic [15:0]      r_deb_cnt;
   logic             r_step_pulse;
   state_t           r_state;
   logic             r_running;
   logic [CNT_W-1:0] r_cnt [N_CH];
   logic [N_CH-1:0]  r_div_clk;
   logic [N_CH-1:0]  r_tick;

   logic [CNT_W-1:0] w_div [N_CH];
   logic [N_CH-1:0]  w_en;
   logic             w_low_tick;

   // Synchroniser plus debouncer: a new level must be seen DEB_CNT times in a row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btn_s1     <= 1'b0;
         r_btn_s2     <= 1'b0;
         r_deb_lvl    <= 1'b0;
         r_deb_cnt    <= '0;
         r_step_pulse <= 1'b0;
      end else begin
         r_btn_s1     <= bus.step_btn;
         r_btn_s2     <= r_btn_s1;
         r_step_pulse <= 1'b0;
         if (r_btn_s2 == r_deb_lvl) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == DEB_CNT - 16'd1) begin
            r_deb_lvl    <= r_btn_s2;
            r_deb_cnt    <= '0;
            r_step_pulse <= r_btn_s2;
         end else begin
            r_deb_cnt <= r_deb_cnt + 16'd1;
         end
      end
   end

   // Tick of the lowest-index gated channel ends a single step.
   always_comb begin
      w_low_tick = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (GATE_MASK[i]) w_low_tick = r_tick[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_STOP;
         r_running <= 1'b0;
      end else begin
         case (bus.mode)
            2'b00: begin
               r_state   <= S_STOP;
               r_running <= 1'b0;
            end
            2'b01: begin
               if (r_state == S_ARMED) begin
                  if (w_low_tick) begin
                     r_state   <= S_WAIT;
                     r_running <= 1'b0;
                  end else begin
                     r_running <= 1'b1;
                  end
               end else if (r_step_pulse) begin
                  r_state   <= S_ARMED;
                  r_running <= 1'b1;
               end else begin
                  r_state   <= S_WAIT;
                  r_running <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_RUN;
               r_running <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         w_div[i] = bus.div_val[i*CNT_W +: CNT_W];
         w_en[i]  = ~GATE_MASK[i] | r_running;
      end
   end

   // The >= compare also recovers when div_val drops below the running count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
         r_div_clk <= '0;
         r_tick    <= '0;
`ifdef CLK_EN_GEN_SYNC_RESTART_EN
      end else if (bus.sync_restart) begin
         for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
         r_div_clk <= '0;
         r_tick    <= '0;
`endif
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            r_tick[i] <= 1'b0;
            if (w_en[i]) begin
               if (r_cnt[i] >= w_div[i]) begin
                  r_cnt[i]     <= '0;
                  r_div_clk[i] <= ~r_div_clk[i];
                  r_tick[i]    <= ~r_div_clk[i];
               end else begin
                  r_cnt[i] <= r_cnt[i] + ONE;
               end
            end
         end
      end
   end

`ifndef CLK_EN_GEN_SYNC_RESTART_EN
   logic w_unused_sync;
   assign w_unused_sync = bus.sync_restart;
`endif

   assign bus.div_clk    = r_div_clk;
   assign bus.tick       = r_tick;
   assign bus.step_pulse = r_step_pulse;
   assign bus.running    = r_running;

endmodule

// File: tb/tb_clk_en_gen.sv
// Randomised bench for clk_en_gen: a cycle-level reference model queues the expected
// outputs on every clock edge, and an independent monitor compares them mid-cycle.
module tb_clk_en_gen;
   localparam int             N   = 5;
   localparam int             W   = 32;
   localparam logic [N-1:0]   GM  = 5'b00111;
   localparam int             DEB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   clk_en_gen_if #(.N_CH(N), .CNT_W(W)) bus ();

   clk_en_gen #(.N_CH(N), .CNT_W(W), .GATE_MASK(GM), .DEB_CNT(16'(DEB))) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct packed {
      logic [N-1:0] dclk;
      logic [N-1:0] tick;
      logic         pulse;
      logic         run;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: per-channel cycles elapsed since the last toggle,
   // a window of recent synchronised button samples, and the step/run status.
   logic        m_s1, m_s2, m_acc;
   logic        hist[$];
   logic        m_pulse, m_run, m_armed;
   int unsigned m_age [N];
   logic [N-1:0] m_clk, m_tick;

   task automatic mreset();
      m_s1 = 0; m_s2 = 0; m_acc = 0;
      hist.delete();
      m_pulse = 0; m_run = 0; m_armed = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      m_clk = '0; m_tick = '0;
   endtask

   always @(posedge clk) begin
      logic lt, np, nr, na, same;
      logic [N-1:0] nclk, ntick;
      int unsigned d;
      obs_t e;
      if (!rst) begin
         mreset();
      end else begin
         lt = 1'b0;
         for (int i = N - 1; i >= 0; i--) if (GM[i]) lt = m_tick[i];
         np = 1'b0;
         hist.push_back(m_s2);
         if (hist.size() > DEB) void'(hist.pop_front());
         if (hist.size() == DEB) begin
            same = 1'b1;
            foreach (hist[k]) if (hist[k] != hist[0]) same = 1'b0;
            if (same && hist[0] != m_acc) begin
               m_acc = hist[0];
               np    = hist[0];
            end
         end
         m_s2 = m_s1;
         m_s1 = bus.step_btn;
         case (bus.mode)
            2'b00:   begin na = 0; nr = 0; end
            2'b01:   begin na = m_armed ? !lt : m_pulse; nr = na; end
            default: begin na = 0; nr = 1; end
         endcase
         for (int i = 0; i < N; i++) begin
            ntick[i] = 1'b0;
            nclk[i]  = m_clk[i];
            if (!GM[i] || m_run) begin
               d = bus.div_val[i*W +: W];
               if (m_age[i] >= d) begin
                  m_age[i] = 0;
                  nclk[i]  = !m_clk[i];
                  ntick[i] = nclk[i];
               end else begin
                  m_age[i] = m_age[i] + 1;
               end
            end
         end
`ifdef CLK_EN_GEN_SYNC_RESTART_EN
         if (bus.sync_restart) begin
            for (int i = 0; i < N; i++) m_age[i] = 0;
            nclk = '0; ntick = '0;
         end
`endif
         m_pulse = np; m_run = nr; m_armed = na;
         m_clk = nclk; m_tick = ntick;
         e = '{dclk: nclk, tick: ntick, pulse: np, run: nr};
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      obs_t e, a;
      if (rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{dclk: bus.div_clk, tick: bus.tick, pulse: bus.step_pulse, run: bus.running};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got dclk=%b tick=%b pulse=%b run=%b want dclk=%b tick=%b pulse=%b run=%b",
                     $time, a.dclk, a.tick, a.pulse, a.run, e.dclk, e.tick, e.pulse, e.run);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_div(input int ch, input int unsigned v);
      bus.div_val[ch*W +: W] = v;
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if ({bus.div_clk, bus.tick, bus.step_pulse, bus.running} !== '0) begin
         errors++;
         $display("FAIL %s got dclk=%b tick=%b pulse=%b run=%b want all zero",
                  nm, bus.div_clk, bus.tick, bus.step_pulse, bus.running);
      end
   endtask

   task automatic press();
      bus.step_btn = 1; cyc(1);
      bus.step_btn = 0; cyc(1);
      bus.step_btn = 1; cyc(12);
      bus.step_btn = 0; cyc(14);
   endtask

   initial begin
      bus.mode = 2'b00; bus.step_btn = 0; bus.sync_restart = 0; bus.div_val = '0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset_state");
      @(negedge clk) rst = 1;

      // run mode: ch0 period 8, others free
      bus.mode = 2'b10;
      set_div(0, 3);
      for (int i = 1; i < N; i++) set_div(i, $urandom_range(0, 4));
      cyc(60);

      // stop: gated channels freeze, ch3 keeps toggling
      bus.mode = 2'b00;
      set_div(3, 1);
      cyc(30);

      // step presses with bounce
      bus.mode = 2'b01;
      repeat (4) press();
      cyc(10);

      // lower ch1 divider mid-count
      bus.mode = 2'b10;
      set_div(1, 10);
      cyc(3);
      begin
         bit hit = 0;
         for (int k = 0; k < 40 && !hit; k++) begin
            if (m_age[1] == 7) hit = 1;
            else cyc(1);
         end
         checks++;
         if (!hit) begin
            errors++;
            $display("FAIL wait_cnt7 got timeout want ch1 count 7");
         end
      end
      set_div(1, 2);
      cyc(30);

      // random mixed traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 29) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) set_div($urandom_range(0, N - 1), $urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) bus.step_btn = ~bus.step_btn;
         bus.sync_restart = ($urandom_range(0, 99) == 0);
         cyc(1);
      end
      bus.sync_restart = 0;

      // async reset while a step is armed
      bus.mode = 2'b01; bus.step_btn = 0;
      set_div(0, 5);
      cyc(12);
      bus.step_btn = 1;
      begin
         bit armed = 0;
         for (int k = 0; k < 30 && !armed; k++) begin
            if (m_armed) armed = 1;
            else cyc(1);
         end
         checks++;
         if (!armed) begin
            errors++;
            $display("FAIL wait_armed got timeout want step armed");
         end
      end
      cyc(2);
      @(posedge clk);
      #2 rst = 0;
      #1 check_zero("async_reset");
      exp_q.delete();
      cyc(2);
      rst = 1;
      cyc(3);
      bus.step_btn = 0;
      cyc(20);
      press();
      cyc(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
